banked_memory_wbuf: RTL and testbench



---
 rtl/banked_memory_wbuf_if.sv | 34 +++
 rtl/banked_memory_wbuf.sv | 135 +++++++++++++
 tb/tb_banked_memory_wbuf.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/banked_memory_wbuf_if.sv
// banked_memory_wbuf_if
//   Bus bundle for the banked scratch memory with a one-entry write buffer.
//   master : read/write requester (drives ren/raddr/wen/waddr/din)
//   slave  : memory (drives w_ready/dout/dout_valid/conflict_cnt)
//   ren, raddr         read request and address
//   wen, waddr, din    write request, address, data (taken only when w_ready=1)
//   w_ready            write buffer empty
//   dout, dout_valid   read data, one cycle after the read request
//   conflict_cnt       saturating count of writes diverted to the buffer
interface banked_memory_wbuf_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) ();
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] din;
  logic              w_ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output ren, raddr, wen, waddr, din,
    input  w_ready, dout, dout_valid, conflict_cnt
  );

  modport slave (
    input  ren, raddr, wen, waddr, din,
    output w_ready, dout, dout_valid, conflict_cnt
  );
endinterface

// File: rtl/banked_memory_wbuf.sv
// banked_memory_wbuf
//   NUM_BANK x NUM_SUB sub-banks of SUB_DEPTH x DATA_W words. One read and one
//   write may be issued per cycle. Each sub-bank does one access per cycle, so
//   a write landing in the read's sub-bank is parked in a one-entry pending
//   buffer and retired on a later cycle when its sub-bank is free. Reads of
//   the pending address are forwarded from the buffer.
//   Address layout: {bank, sub, offset}; the {bank, sub} field is the sub-bank id.
// Ports
//   clk  clock, rising edge
//   rst  synchronous active-high reset (drops any pending write)
//   bus  banked_memory_wbuf_if.slave (request/response signals)
module banked_memory_wbuf #(
  parameter int DATA_W    = 8,
  parameter int NUM_BANK  = 4,
  parameter int NUM_SUB   = 4,
  parameter int SUB_DEPTH = 128,
  parameter int CNT_W     = 8
) (
  input logic                 clk,
  input logic                 rst,
  banked_memory_wbuf_if.slave bus
);
  localparam int OFF_W   = $clog2(SUB_DEPTH);
  localparam int ID_W    = $clog2(NUM_BANK) + $clog2(NUM_SUB);
  localparam int ADDR_W  = ID_W + OFF_W;
  localparam int NUM_IDS = NUM_BANK * NUM_SUB;

  // Address fields
  logic [ID_W-1:0]  r_id, w_id, p_id, wr_id;
  logic [OFF_W-1:0] r_off, wr_off;

  // Pending-write buffer and response state
  logic              pvalid_q, pvalid_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dout_valid_q, dout_valid_d;
  logic              fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [ID_W-1:0]   rsel_q, rsel_d;

  // Single physical write port shared by retiring and new writes
  logic              retire, accept, conflict, wr_en, fwd;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [NUM_IDS-1:0][DATA_W-1:0] rd_bus;

  assign r_id   = bus.raddr[ADDR_W-1:OFF_W];
  assign r_off  = bus.raddr[OFF_W-1:0];
  assign w_id   = bus.waddr[ADDR_W-1:OFF_W];
  assign p_id   = paddr_q[ADDR_W-1:OFF_W];
  assign wr_id  = wr_addr[ADDR_W-1:OFF_W];
  assign wr_off = wr_addr[OFF_W-1:0];

  always_comb begin
    // The read owns its sub-bank this cycle; the pending entry waits if it collides.
    retire   = pvalid_q && !(bus.ren && (r_id == p_id));
    // A new write is only taken with an empty buffer, so it never competes with a retire.
    accept   = bus.wen && !pvalid_q;
    conflict = accept && bus.ren && (r_id == w_id);
    // Nothing reaches the arrays on a reset edge: a pending write is dropped, not committed.
    wr_en    = !rst && (retire || (accept && !conflict));
    wr_addr  = pvalid_q ? paddr_q : bus.waddr;
    wr_data  = pvalid_q ? pdata_q : bus.din;
    fwd      = bus.ren && pvalid_q && (bus.raddr == paddr_q);
  end

  always_comb begin
    pvalid_d     = pvalid_q;
    paddr_d      = paddr_q;
    pdata_d      = pdata_q;
    cnt_d        = cnt_q;
    dout_valid_d = bus.ren;
    fwd_d        = fwd;
    fwd_data_d   = pdata_q;
    rsel_d       = r_id;
    if (retire) begin
      pvalid_d = 1'b0;
    end
    if (conflict) begin
      pvalid_d = 1'b1;
      paddr_d  = bus.waddr;
      pdata_d  = bus.din;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pvalid_q     <= 1'b0;
      cnt_q        <= '0;
      dout_valid_q <= 1'b0;
      fwd_q        <= 1'b0;
    end else begin
      pvalid_q     <= pvalid_d;
      paddr_q      <= paddr_d;
      pdata_q      <= pdata_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= dout_valid_d;
      fwd_q        <= fwd_d;
      fwd_data_q   <= fwd_data_d;
      rsel_q       <= rsel_d;
    end
  end

  // One RAM per sub-bank with a registered read; the read samples the word
  // before any write of the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IDS; gi++) begin : g_sub
      logic [DATA_W-1:0] mem [SUB_DEPTH];
      logic [DATA_W-1:0] rd_q;

      always_ff @(posedge clk) begin
        if (wr_en && (wr_id == ID_W'(gi))) begin
          mem[wr_off] <= wr_data;
        end
        if (bus.ren && (r_id == ID_W'(gi))) begin
          rd_q <= mem[r_off];
        end
      end

      assign rd_bus[gi] = rd_q;
    end
  endgenerate

  // dout is zero on cycles without a read response.
  assign bus.dout         = dout_valid_q ? (fwd_q ? fwd_data_q : rd_bus[rsel_q]) : '0;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.w_ready      = !pvalid_q;
  assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_banked_memory_wbuf.sv
module tb_banked_memory_wbuf;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  banked_memory_wbuf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if ();

  banked_memory_wbuf #(
    .DATA_W(DATA_W), .NUM_BANK(4), .NUM_SUB(4), .SUB_DEPTH(128), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [DATA_W-1:0] m_mem [1 << ADDR_W];
  logic              m_pvalid;
  logic [ADDR_W-1:0] m_paddr;
  logic [DATA_W-1:0] m_pdata;
  logic [CNT_W-1:0]  m_cnt;

  // Scoreboard of expected {dout_valid, dout}
  logic [DATA_W:0] sb [$];

  function automatic logic [3:0] sub_id(input logic [ADDR_W-1:0] a);
    return a[10:7];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [ADDR_W-1:0] ra,
                      input logic w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W:0]   got;
    logic              retire, accept, conf;
    bus_if.ren   = r;
    bus_if.raddr = ra;
    bus_if.wen   = w;
    bus_if.waddr = wa;
    bus_if.din   = d;
    exp_data = '0;
    if (r) exp_data = (m_pvalid && (ra == m_paddr)) ? m_pdata : m_mem[ra];
    sb.push_back({r, exp_data});
    @(posedge clk);
    retire = m_pvalid && !(r && (sub_id(ra) == sub_id(m_paddr)));
    accept = w && !m_pvalid;
    conf   = accept && r && (sub_id(ra) == sub_id(wa));
    if (retire) begin
      m_mem[m_paddr] = m_pdata;
      m_pvalid = 1'b0;
    end
    if (accept && !conf) m_mem[wa] = d;
    if (conf) begin
      m_pvalid = 1'b1;
      m_paddr  = wa;
      m_pdata  = d;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    #1;
    got = sb.pop_front();
    $display("txn ren=%0b raddr=%03h wen=%0b waddr=%03h din=%02h -> dout=%02h v=%0b w_ready=%0b cnt=%0d",
             r, ra, w, wa, d, bus_if.dout, bus_if.dout_valid, bus_if.w_ready, bus_if.conflict_cnt);
    check("dout", 32'(bus_if.dout), 32'(got[DATA_W-1:0]));
    check("dout_valid", 32'(bus_if.dout_valid), 32'(got[DATA_W]));
    check("w_ready", 32'(bus_if.w_ready), 32'(!m_pvalid));
    check("conflict_cnt", 32'(bus_if.conflict_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.ren = 1'b0;
    bus_if.wen = 1'b0;
    @(posedge clk);
    m_pvalid = 1'b0;
    m_cnt    = '0;
    #1;
    rst = 1'b0;
    $display("txn reset -> dout=%02h v=%0b w_ready=%0b cnt=%0d",
             bus_if.dout, bus_if.dout_valid, bus_if.w_ready, bus_if.conflict_cnt);
    check("rst_dout", 32'(bus_if.dout), 32'h0);
    check("rst_dout_valid", 32'(bus_if.dout_valid), 32'h0);
    check("rst_w_ready", 32'(bus_if.w_ready), 32'h1);
    check("rst_conflict_cnt", 32'(bus_if.conflict_cnt), 32'h0);
  endtask

  initial begin
    logic [ADDR_W-1:0] pre [8];
    logic [ADDR_W-1:0] a;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus_if.ren = 1'b0; bus_if.raddr = '0;
    bus_if.wen = 1'b0; bus_if.waddr = '0; bus_if.din = '0;
    m_pvalid = 1'b0; m_paddr = '0; m_pdata = '0; m_cnt = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Plain write then read-back
    step(1'b0, 11'h000, 1'b1, 11'h057, 8'd87);
    step(1'b1, 11'h057, 1'b0, 11'h000, 8'd0);

    // Preload every address read later without a prior write
    pre = '{11'h08F, 11'h080, 11'h100, 11'h110, 11'h200, 11'h130, 11'h000, 11'h301};
    for (int i = 0; i < 8; i++) step(1'b0, 11'h000, 1'b1, pre[i], 8'(8'h10 + i));

    // Conflict in sub-bank 1, retire on an idle cycle, read back
    step(1'b1, 11'h08F, 1'b1, 11'h0D7, 8'd85);
    step(1'b0, 11'h000, 1'b0, 11'h000, 8'd0);
    step(1'b1, 11'h0D7, 1'b0, 11'h000, 8'd0);

    // Forwarding of the pending word while its retire is stalled
    step(1'b1, 11'h080, 1'b1, 11'h0A0, 8'h33);
    step(1'b1, 11'h0A0, 1'b0, 11'h000, 8'd0);
    step(1'b0, 11'h000, 1'b0, 11'h000, 8'd0);
    step(1'b1, 11'h0A0, 1'b0, 11'h000, 8'd0);

    // Held conflict: new writes ignored while the buffer is full
    step(1'b1, 11'h100, 1'b1, 11'h120, 8'h44);
    for (int i = 0; i < 5; i++) step(1'b1, 11'h110, 1'b1, 11'h130, 8'h55);
    step(1'b1, 11'h200, 1'b1, 11'h130, 8'h55);
    step(1'b1, 11'h120, 1'b0, 11'h000, 8'd0);
    step(1'b1, 11'h130, 1'b0, 11'h000, 8'd0);

    // Same address: old value on the colliding read, new value afterwards
    step(1'b0, 11'h000, 1'b1, 11'h157, 8'hAA);
    step(1'b1, 11'h157, 1'b1, 11'h157, 8'hBB);
    step(1'b1, 11'h157, 1'b0, 11'h000, 8'd0);
    step(1'b0, 11'h000, 1'b0, 11'h000, 8'd0);
    step(1'b1, 11'h157, 1'b0, 11'h000, 8'd0);
    // Different sub-banks in the same cycle proceed together
    step(1'b1, 11'h157, 1'b1, 11'h057, 8'h99);
    step(1'b1, 11'h057, 1'b1, 11'h0D7, 8'h77);
    step(1'b1, 11'h0D7, 1'b0, 11'h000, 8'd0);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 11'h000, 1'b1, 11'h010, 8'(i));
      step(1'b0, 11'h000, 1'b0, 11'h000, 8'd0);
    end
    step(1'b1, 11'h010, 1'b0, 11'h000, 8'd0);

    // Reset with a pending write: it must be dropped
    step(1'b0, 11'h000, 1'b1, 11'h300, 8'h5A);
    step(1'b1, 11'h301, 1'b1, 11'h300, 8'hA5);
    do_reset();
    step(1'b1, 11'h300, 1'b0, 11'h000, 8'd0);

    // Sweep all sub-banks: write {bank, sub} patterns, then read back
    for (int i = 0; i < 16; i++) begin
      a = {4'(i), 7'h05};
      step(1'b0, 11'h000, 1'b1, a, 8'(8'hC0 | i));
    end
    for (int i = 0; i < 16; i++) begin
      a = {4'(i), 7'h05};
      step(1'b1, a, 1'b1, {4'(15 - i), 7'h06}, 8'(i));
    end
    for (int i = 0; i < 16; i++) begin
      a = {4'(i), 7'h06};
      step(1'b1, a, 1'b0, 11'h000, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
